uart_rx_shift_register: RTL and testbench

Receive-side counterpart of the UART transmit shift register. It oversamples the UART RX pin and recovers start, data, parity and stop bits by majority vote. Each good frame is written into the receive FIFO as one byte. It sits between the RX pad and the receive FIFO and shares the baud generator, which supplies a 16× sample strobe, with the TX path.

---
 rtl/uart_rx_shift_register_pkg.sv | 29 ++
 rtl/uart_rx_shift_register_voter.sv | 68 ++++++
 rtl/uart_rx_shift_register.sv | 155 +++++++++++++++
 tb/tb_uart_rx_shift_register.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_shift_register_pkg.sv
// Shared UART definitions for the TX and RX shift registers: one-hot states,
// FIFO status and byte-order constants, default oversampling and a vote helper.
package uart_rx_shift_register_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_STARTBIT  = 5'b00010,
        ST_DATABITS  = 5'b00100,
        ST_PARITYBIT = 5'b01000,
        ST_STOPBIT   = 5'b10000
    } uart_state_e;

    // The TX side calls the between-frames state INTERVAL.
    localparam uart_state_e ST_INTERVAL = ST_IDLE;

    localparam logic FIFO_EMPTY    = 1'b1;
    localparam logic FIFO_NONEMPTY = 1'b0;
    localparam logic FIFO_FULL     = 1'b1;

    localparam logic BIGEND    = 1'b1;
    localparam logic LITTLEEND = 1'b0;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_shift_register_voter.sv
// RX front end: 2-flop synchronizer, per-bit sample counter and 2-of-3 vote
// around the middle of each bit.
module rx_sample_voter
    import uart_rx_shift_register_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int VOTE_MID   = OVERSAMPLE / 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic serial_i,
    input  logic cnt_clr_i,
    output logic sync_o,
    output logic vote_done_o,
    output logic voted_o,
    output logic wrap_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] IDX_A   = CW'(VOTE_MID - 1);
    localparam logic [CW-1:0] IDX_B   = CW'(VOTE_MID);
    localparam logic [CW-1:0] IDX_C   = CW'(VOTE_MID + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          samp_a_q, samp_a_d;
    logic          samp_b_q, samp_b_d;

    // cnt_d is the index of the sample taken on this strobe; the detecting
    // strobe in IDLE is sample 0 of the start bit.
    always_comb begin
        sync_d      = {sync_q[0], serial_i};
        cnt_d       = cnt_q;
        samp_a_d    = samp_a_q;
        samp_b_d    = samp_b_q;
        wrap_o      = 1'b0;
        vote_done_o = 1'b0;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            wrap_o = (cnt_q == CNT_MAX);
            cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;
            if (cnt_d == IDX_A) samp_a_d = sync_q[1];
            if (cnt_d == IDX_B) samp_b_d = sync_q[1];
            vote_done_o = (cnt_d == IDX_C);
        end
    end

    assign sync_o  = sync_q[1];
    assign voted_o = maj3(samp_a_q, samp_b_q, sync_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            samp_a_q <= samp_a_d;
            samp_b_q <= samp_b_d;
        end
    end

endmodule

// File: rtl/uart_rx_shift_register.sv
// UART receive shift register: frames start/data/parity/stop from voted samples
// and writes each good byte to the RX FIFO, flagging parity/frame/overrun errors.
module uart_rx_shift_register
    import uart_rx_shift_register_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int VOTE_MID   = OVERSAMPLE / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_SampleSig_i,
    input  logic       SerialData_i,
    input  logic       p_BigEnd_i,
    input  logic       p_ParityEn_i,
    input  logic       p_ParityOdd_i,
    input  logic       p_FifoFull_i,
    output logic       n_FifoWe_o,
    output logic [7:0] FifoData_o,
    output logic [4:0] State_o,
    output logic [3:0] BitCounter_o,
    output logic       p_ParityErr_o,
    output logic       p_FrameErr_o,
    output logic       p_Overrun_o
);

    uart_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  fifo_data_q, fifo_data_d;
    logic        big_q, big_d, par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic        perr_flag_q, perr_flag_d;
    logic        n_we_q, n_we_d;
    logic        perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic [2:0]  bit_idx;

    logic sync_bit, vote_done, voted_bit, bit_wrap;

    rx_sample_voter #(
        .OVERSAMPLE (OVERSAMPLE),
        .VOTE_MID   (VOTE_MID)
    ) u_voter (
        .clk         (clk),
        .rst_n       (rst),
        .sample_i    (p_SampleSig_i),
        .serial_i    (SerialData_i),
        .cnt_clr_i   (state_q == ST_IDLE),
        .sync_o      (sync_bit),
        .vote_done_o (vote_done),
        .voted_o     (voted_bit),
        .wrap_o      (bit_wrap)
    );

    assign bit_idx = big_q ? (3'd7 - bit_cnt_q) : bit_cnt_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        fifo_data_d = fifo_data_q;
        big_d       = big_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        perr_flag_d = perr_flag_q;
        n_we_d      = 1'b1;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (p_SampleSig_i && !sync_bit) begin
                    state_d     = ST_STARTBIT;
                    bit_cnt_d   = '0;
                    perr_flag_d = 1'b0;
                    big_d       = (p_BigEnd_i == BIGEND);
                    par_en_d    = p_ParityEn_i;
                    par_odd_d   = p_ParityOdd_i;
                end
            end
            ST_STARTBIT: begin
                if (vote_done && voted_bit) state_d = ST_IDLE;
                else if (bit_wrap)          state_d = ST_DATABITS;
            end
            ST_DATABITS: begin
                if (vote_done) data_d[bit_idx] = voted_bit;
                if (bit_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITYBIT : ST_STOPBIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITYBIT: begin
                if (vote_done) perr_flag_d = ((^data_q) ^ voted_bit) != par_odd_q;
                if (bit_wrap)  state_d = ST_STOPBIT;
            end
            ST_STOPBIT: begin
                // Back to IDLE at mid-stop so a fast sender's next start is caught.
                if (vote_done) begin
                    state_d = ST_IDLE;
                    if (!voted_bit) begin
                        ferr_d = 1'b1;
                    end else if (p_FifoFull_i == FIFO_FULL) begin
                        ovr_d = 1'b1;
                    end else begin
                        n_we_d      = 1'b0;
                        fifo_data_d = data_q;
                        perr_d      = perr_flag_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            perr_flag_q <= 1'b0;
            fifo_data_q <= '0;
            n_we_q      <= 1'b1;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            perr_flag_q <= perr_flag_d;
            fifo_data_q <= fifo_data_d;
            n_we_q      <= n_we_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    // Assembly byte and frame config are always rewritten before use.
    always_ff @(posedge clk) begin
        data_q    <= data_d;
        big_q     <= big_d;
        par_en_q  <= par_en_d;
        par_odd_q <= par_odd_d;
    end

    assign State_o       = state_q;
    assign BitCounter_o  = {1'b0, bit_cnt_q};
    assign FifoData_o    = fifo_data_q;
    assign n_FifoWe_o    = n_we_q;
    assign p_ParityErr_o = perr_q;
    assign p_FrameErr_o  = ferr_q;
    assign p_Overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_shift_register.sv
// Randomized frame bench for uart_rx_shift_register with a frame-level reference model.
module tb_uart_rx_shift_register;

    localparam int OS  = 16;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_SampleSig_i = 1'b0;
    logic       SerialData_i = 1'b1;
    logic       p_BigEnd_i = 1'b0;
    logic       p_ParityEn_i = 1'b0;
    logic       p_ParityOdd_i = 1'b0;
    logic       p_FifoFull_i = 1'b0;
    logic       n_FifoWe_o;
    logic [7:0] FifoData_o;
    logic [4:0] State_o;
    logic [3:0] BitCounter_o;
    logic       p_ParityErr_o, p_FrameErr_o, p_Overrun_o;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          div_cnt = 0;
    logic [11:0] ev_q[$];
    logic [7:0]  last_byte = 8'h00;

    uart_rx_shift_register dut (
        .clk           (clk),
        .rst           (rst),
        .p_SampleSig_i (p_SampleSig_i),
        .SerialData_i  (SerialData_i),
        .p_BigEnd_i    (p_BigEnd_i),
        .p_ParityEn_i  (p_ParityEn_i),
        .p_ParityOdd_i (p_ParityOdd_i),
        .p_FifoFull_i  (p_FifoFull_i),
        .n_FifoWe_o    (n_FifoWe_o),
        .FifoData_o    (FifoData_o),
        .State_o       (State_o),
        .BitCounter_o  (BitCounter_o),
        .p_ParityErr_o (p_ParityErr_o),
        .p_FrameErr_o  (p_FrameErr_o),
        .p_Overrun_o   (p_Overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        div_cnt       = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
        p_SampleSig_i = (div_cnt == 0);
    end

    // Every cycle with a write or error pulse becomes one event word.
    always @(negedge clk) begin
        if (!n_FifoWe_o || p_ParityErr_o || p_FrameErr_o || p_Overrun_o)
            ev_q.push_back({~n_FifoWe_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o, FifoData_o});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, State_o, 5'b00001);
        chk({tag, "_bitcnt"}, BitCounter_o, 4'd0);
        chk({tag, "_we"}, n_FifoWe_o, 1'b1);
        chk({tag, "_data"}, FifoData_o, 8'h00);
        chk({tag, "_errs"}, {p_ParityErr_o, p_FrameErr_o, p_Overrun_o}, 3'b000);
    endtask

    // wb[i] is the i-th data bit on the wire; spike >= 0 puts a one-sample
    // inverted pulse at mid-bit of that data bit.
    task automatic run_frame(input string tag, input logic [7:0] wb, input logic big,
                             input logic pen, input logic podd, input logic pbit,
                             input logic stopv, input logic full, input logic scr,
                             input int spike, input int gap);
        logic [7:0]  byte_v;
        logic        perr;
        logic [11:0] exp_ev;
        ev_q.delete();
        p_BigEnd_i    = big;
        p_ParityEn_i  = pen;
        p_ParityOdd_i = podd;
        p_FifoFull_i  = full;
        SerialData_i  = 1'b0;
        clks(4 * DIV);
        if (scr) begin
            p_BigEnd_i    = 1'($urandom);
            p_ParityEn_i  = 1'($urandom);
            p_ParityOdd_i = 1'($urandom);
        end
        clks(12 * DIV);
        for (int i = 0; i < 8; i++) begin
            SerialData_i = wb[i];
            if (i == spike) begin
                clks(8 * DIV);
                SerialData_i = ~wb[i];
                clks(DIV);
                SerialData_i = wb[i];
                clks(7 * DIV);
            end else begin
                clks(OS * DIV);
            end
        end
        if (pen) begin
            SerialData_i = pbit;
            clks(OS * DIV);
        end
        SerialData_i = stopv;
        clks(OS * DIV);
        SerialData_i = 1'b1;
        clks(gap * DIV + (stopv ? 0 : 20 * OS / 16 * DIV));

        byte_v = big ? {<<{wb}} : wb;
        perr   = pen && ((($countones(byte_v) + int'(pbit)) % 2) != int'(podd));
        if (!stopv)    exp_ev = {4'b0010, last_byte};
        else if (full) exp_ev = {4'b0001, last_byte};
        else begin
            exp_ev    = {1'b1, perr, 2'b00, byte_v};
            last_byte = byte_v;
        end
        chk({tag, "_nev"}, ev_q.size(), 1);
        if (ev_q.size() > 0) chk({tag, "_ev"}, ev_q[0], exp_ev);
        chk({tag, "_hold"}, FifoData_o, last_byte);
        chk({tag, "_idle"}, State_o, 5'b00001);
        p_FifoFull_i = 1'b0;
    endtask

    initial begin
        clks(3);
        chk_reset_vals("rst0");
        rst = 1'b1;
        clks(OS * DIV);

        run_frame("clean", 8'h5A, 0, 0, 0, 0, 1, 0, 0, -1, 2);
        run_frame("big5a", 8'h5A, 1, 0, 0, 0, 1, 0, 0, -1, 0);
        run_frame("big01", 8'h01, 1, 0, 0, 0, 1, 0, 0, -1, 1);
        run_frame("par_bad", 8'h03, 0, 1, 1, 0, 1, 0, 0, -1, 1);
        run_frame("par_ok", 8'h03, 0, 1, 1, 1, 1, 0, 0, -1, 1);

        // Short low glitch in IDLE: false start, nothing reported.
        ev_q.delete();
        SerialData_i = 1'b0;
        clks(3 * DIV);
        chk("glitch_start", State_o, 5'b00010);
        clks(DIV);
        SerialData_i = 1'b1;
        clks(20 * DIV);
        chk("glitch_idle", State_o, 5'b00001);
        chk("glitch_nev", ev_q.size(), 0);

        run_frame("spike", 8'h0F, 0, 0, 0, 0, 1, 0, 0, 2, 1);
        run_frame("frame_err", 8'h33, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        run_frame("overrun", 8'hFF, 0, 0, 0, 0, 1, 1, 0, -1, 1);

        // Reset during data bit 4 of 0xA5.
        ev_q.delete();
        p_BigEnd_i   = 1'b0;
        p_ParityEn_i = 1'b0;
        SerialData_i = 1'b0;
        clks(OS * DIV);
        for (int i = 0; i < 4; i++) begin
            SerialData_i = 1'(8'hA5 >> i);
            clks(OS * DIV);
        end
        SerialData_i = 1'b0;
        clks(8 * DIV);
        chk("mid_state", State_o, 5'b00100);
        chk("mid_bitcnt", BitCounter_o, 4'd4);
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        last_byte    = 8'h00;
        SerialData_i = 1'b1;
        clks(5);
        rst = 1'b1;
        clks(2 * OS * DIV);
        chk("rst_mid_nev", ev_q.size(), 0);
        run_frame("after_rst", 8'hC3, 0, 0, 0, 0, 1, 0, 0, -1, 1);

        for (int n = 0; n < 36; n++) begin
            run_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                      1'b1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                      int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
